// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module  : uart_rx
// Brief   : 16x-oversampled UART receiver (8N1-style, 5..9 data bits) with
//           majority voting, valid/ack handshake, framing and overrun flags.
// Rev     : 1.0  initial release
// =============================================================================
module uart_rx #(
   parameter int ClockFrequency = 24_000_000,
   parameter int BaudRate       = 9600,
   parameter int NrOfDataBits   = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    rx,
   input  logic                    readAck,
   output logic [NrOfDataBits-1:0] dataBits,
   output logic                    dataValid,
   output logic                    framingError,
   output logic                    overrun,
   output logic                    busy
);

   localparam int c_DIVISOR = (ClockFrequency + BaudRate * 8) / (BaudRate * 16);
   localparam int c_DIV_W   = $clog2(c_DIVISOR + 1);
   localparam int c_BIT_W   = $clog2(NrOfDataBits);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIVISOR - 1);
   localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(NrOfDataBits - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } t_state;

   t_state                    r_state;
   t_state                    w_state_nxt;

   logic                      r_sync1;
   logic                      r_sync2;
   logic                      r_rx_d;
   logic [1:0]                r_fill;
   logic                      r_armed;

   logic [c_DIV_W-1:0]        r_div;
   logic [3:0]                r_sample;
   logic [c_BIT_W-1:0]        r_bitcnt;
   logic                      r_s7;
   logic                      r_s8;
   logic [NrOfDataBits-1:0]   r_shift;

   logic [NrOfDataBits-1:0]   r_data;
   logic                      r_valid;
   logic                      r_overrun;
   logic                      r_ferr;

   logic                      w_fall;
   logic                      w_tick;
   logic                      w_major;
   logic                      w_decide;
   logic                      w_load;
   logic                      w_ferr;

   // Edges are only armed once the line has been seen high through a fully
   // refilled synchronizer, so a line held low across reset is ignored.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rx_d  <= 1'b1;
         r_fill  <= 2'b00;
         r_armed <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_rx_d  <= r_sync2;
         r_fill  <= {r_fill[0], 1'b1};
         if (r_fill[1] && r_sync2) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign w_fall   = r_armed & r_rx_d & ~r_sync2;
   assign w_tick   = (r_state != S_IDLE) && (r_div == c_DIV_LAST);
   assign w_major  = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
   assign w_decide = w_tick && (r_sample == 4'd9);
   assign w_load   = (r_state == S_STOP) && w_decide && w_major;
   assign w_ferr   = (r_state == S_STOP) && w_decide && !w_major;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_decide && w_major) begin
               w_state_nxt = S_IDLE;
            end else if (w_tick && (r_sample == 4'd15)) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_tick && (r_sample == 4'd15) && (r_bitcnt == c_BIT_LAST)) begin
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_decide) begin
               w_state_nxt = w_major ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            if (w_tick && (r_sample == 4'd15) && r_sync2) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Divider and sample counter sit at zero in IDLE, so bit phase starts at the edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_div    <= '0;
         r_sample <= 4'd0;
         r_bitcnt <= '0;
         r_s7     <= 1'b1;
         r_s8     <= 1'b1;
         r_shift  <= '0;
      end else begin
         if (r_state == S_IDLE || r_div == c_DIV_LAST) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + c_DIV_W'(1);
         end

         if (r_state == S_IDLE) begin
            r_sample <= 4'd0;
         end else if (r_state != S_BREAK && w_state_nxt == S_BREAK) begin
            r_sample <= 4'd0;
         end else if (r_state == S_BREAK && !r_sync2) begin
            r_sample <= 4'd0;
         end else if (w_tick) begin
            r_sample <= r_sample + 4'd1;
         end

         if (r_state == S_START) begin
            r_bitcnt <= '0;
         end else if (r_state == S_DATA && w_tick && r_sample == 4'd15) begin
            r_bitcnt <= r_bitcnt + c_BIT_W'(1);
         end

         if (w_tick && r_sample == 4'd7) begin
            r_s7 <= r_sync2;
         end
         if (w_tick && r_sample == 4'd8) begin
            r_s8 <= r_sync2;
         end

         if (r_state == S_DATA && w_decide) begin
            r_shift <= {w_major, r_shift[NrOfDataBits-1:1]};
         end
      end
   end

   // A word load takes priority over a coincident acknowledge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
            if (readAck) begin
               r_overrun <= 1'b0;
            end else if (r_valid) begin
               r_overrun <= 1'b1;
            end
         end else if (readAck && r_valid) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   assign dataBits     = r_data;
   assign dataValid    = r_valid;
   assign overrun      = r_overrun;
   assign framingError = r_ferr;
   assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module  : tb_uart_rx
// Brief   : Scoreboard bench for uart_rx: a line driver queues expected words,
//           an independent monitor pops and compares on each dataValid rise.
// Rev     : 1.0  initial release
// =============================================================================
module tb_uart_rx;

   localparam int CLK_FREQ = 1_280_000;
   localparam int BAUD     = 10_000;
   localparam int NB       = 8;
   localparam int BIT_NS   = 1280;      // 16 x 8 clocks of 10 ns
   localparam int FAST_NS  = 1242;      // transmitter 3 % fast
   localparam int SLOW_NS  = 1318;      // transmitter 3 % slow

   logic          clock    = 1'b0;
   logic          reset    = 1'b0;
   logic          rx       = 1'b1;
   logic          ack_main = 1'b0;
   logic          ack_mon  = 1'b0;
   logic          readAck;
   logic [NB-1:0] dataBits;
   logic          dataValid;
   logic          framingError;
   logic          overrun;
   logic          busy;

   int            tests    = 0;
   int            fails    = 0;
   int            cyc      = 0;
   int            fe_count = 0;
   int            rise_cyc = -1;
   bit            auto_ack = 1'b1;
   bit            prev_v   = 1'b0;
   bit            prev_fe  = 1'b0;
   logic [7:0]    exp_q[$];

   assign readAck = ack_main | ack_mon;

   uart_rx #(
      .ClockFrequency (CLK_FREQ),
      .BaudRate       (BAUD),
      .NrOfDataBits   (NB)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .rx           (rx),
      .readAck      (readAck),
      .dataBits     (dataBits),
      .dataValid    (dataValid),
      .framingError (framingError),
      .overrun      (overrun),
      .busy         (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every new word, counts error pulses.
   initial begin
      forever begin
         @(negedge clock);
         ack_mon = 1'b0;
         if (dataValid && !prev_v) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected word: got 0x%0h, expected none", dataBits);
            end else begin
               check("rx word", 32'(dataBits), 32'(exp_q.pop_front()));
            end
            if (auto_ack) ack_mon = 1'b1;
         end
         if (framingError) begin
            fe_count++;
            check("framingError single cycle", 32'(prev_fe), 32'd0);
         end
         prev_v  = dataValid;
         prev_fe = framingError;
      end
   end

   // Reference line model: start, LSB-first data, stop; line left at stop level.
   task automatic send_frame(input logic [7:0] d, input int bit_ns, input bit stop_hi,
                             input bit expect_word);
      if (expect_word) exp_q.push_back(d);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < NB; i++) begin
         rx = d[i];
         #(bit_ns);
      end
      rx = stop_hi;
      #(bit_ns);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 4000) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic pulse_ack();
      @(negedge clock);
      ack_main = 1'b1;
      @(negedge clock);
      ack_main = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int lat;
      int fe0;
      bit busy_seen;
      logic [7:0] d;

      // Reset state
      repeat (3) @(negedge clock);
      check("reset dataBits", 32'(dataBits), 32'd0);
      check("reset flags", {28'd0, dataValid, framingError, overrun, busy}, 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clock);

      // 0xA5, held without acknowledge, latency measured from start edge
      auto_ack = 1'b0;
      fe0 = fe_count;
      s = cyc;
      send_frame(8'hA5, BIT_NS, 1'b1, 1'b1);
      lat = rise_cyc - s;
      check("A5 latency window", 32'(lat >= 153 * 8 && lat <= 155 * 8 + 4), 32'd1);
      check("A5 dataValid", 32'(dataValid), 32'd1);
      check("A5 overrun", 32'(overrun), 32'd0);
      check("A5 framing count", 32'(fe_count - fe0), 32'd0);

      // Short low glitch: rejected, held word untouched
      rx = 1'b0;
      #300;
      check("glitch busy", 32'(busy), 32'd1);
      #200;
      rx = 1'b1;
      #(2 * BIT_NS);
      check("glitch back to idle", 32'(busy), 32'd0);
      check("glitch dataBits kept", 32'(dataBits), 32'hA5);
      check("glitch dataValid kept", 32'(dataValid), 32'd1);
      check("glitch framing count", 32'(fe_count - fe0), 32'd0);
      pulse_ack();
      check("ack clears valid", 32'(dataValid), 32'd0);
      pulse_ack();
      check("ack when empty", {30'd0, dataValid, overrun}, 32'd0);

      auto_ack = 1'b1;
      send_frame(8'h3C, BIT_NS, 1'b1, 1'b1);
      wait_drain("3C drain");

      // Framing error followed by a break, then recovery
      fe0 = fe_count;
      send_frame(8'h3C, BIT_NS, 1'b0, 1'b0);
      #(3 * BIT_NS);
      check("framing pulse count", 32'(fe_count - fe0), 32'd1);
      check("framing no valid", 32'(dataValid), 32'd0);
      rx = 1'b1;
      #(2 * BIT_NS);
      check("break recovered", 32'(busy), 32'd0);
      send_frame(8'h11, BIT_NS, 1'b1, 1'b1);
      wait_drain("11 drain");

      // Back-to-back without acknowledge: overrun
      auto_ack = 1'b0;
      send_frame(8'h01, BIT_NS, 1'b1, 1'b1);
      send_frame(8'h02, BIT_NS, 1'b1, 1'b0);
      check("overrun dataBits", 32'(dataBits), 32'h02);
      check("overrun flags", {30'd0, dataValid, overrun}, 32'd3);
      pulse_ack();
      check("overrun ack clears", {30'd0, dataValid, overrun}, 32'd0);

      // Back-to-back with acknowledge coincident with the second load
      @(negedge clock);
      s = cyc;
      fork
         begin
            send_frame(8'h01, BIT_NS, 1'b1, 1'b1);
            send_frame(8'h02, BIT_NS, 1'b1, 1'b0);
         end
         begin
            while (cyc < s + 10 * 128 + lat - 1) @(negedge clock);
            ack_main = 1'b1;
            @(negedge clock);
            ack_main = 1'b0;
         end
      join
      check("coincident dataBits", 32'(dataBits), 32'h02);
      check("coincident flags", {30'd0, dataValid, overrun}, 32'd2);
      pulse_ack();
      auto_ack = 1'b1;

      // Reset mid-frame, released while the line is still low
      rx = 1'b0;
      #(BIT_NS);
      rx = 1'b1;
      #(4 * BIT_NS);
      check("mid-frame busy", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("async reset dataBits", 32'(dataBits), 32'd0);
      check("async reset flags", {28'd0, dataValid, framingError, overrun, busy}, 32'd0);
      rx = 1'b0;
      #100;
      reset = 1'b1;
      busy_seen = 1'b0;
      repeat (3 * 128) begin
         @(negedge clock);
         if (busy) busy_seen = 1'b1;
      end
      check("stale low ignored", 32'(busy_seen), 32'd0);
      rx = 1'b1;
      #(2 * BIT_NS);
      send_frame(8'h5A, BIT_NS, 1'b1, 1'b1);
      wait_drain("5A drain");

      // +-3 % transmitter rate
      fe0 = fe_count;
      send_frame(8'h00, FAST_NS, 1'b1, 1'b1);
      send_frame(8'hFF, FAST_NS, 1'b1, 1'b1);
      send_frame(8'h55, FAST_NS, 1'b1, 1'b1);
      send_frame(8'h00, SLOW_NS, 1'b1, 1'b1);
      send_frame(8'hFF, SLOW_NS, 1'b1, 1'b1);
      send_frame(8'h55, SLOW_NS, 1'b1, 1'b1);
      wait_drain("tolerance drain");
      check("tolerance framing count", 32'(fe_count - fe0), 32'd0);

      // Randomized words, rates and idle gaps
      for (int k = 0; k < 20; k++) begin
         d = 8'($urandom_range(0, 255));
         send_frame(d, FAST_NS + int'($urandom_range(0, 76)), 1'b1, 1'b1);
         #($urandom_range(0, 2 * BIT_NS));
      end
      wait_drain("random drain");
      check("random framing count", 32'(fe_count - fe0), 32'd0);
      check("final overrun", 32'(overrun), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver. It is the receive-side counterpart of the team's UartTx and uses the same frame format: 1 start bit, NrOfDataBits data bits sent LSB first, no parity, 1 stop bit.
- It samples the line at 16x the baud rate and applies majority voting.
- It holds each received word for the consumer with a valid/acknowledge handshake, and reports framing and overrun errors.
- It sits at the top level next to UartTx, on the same clock and reset.

Parameters:
- ClockFrequency, 24_000_000, system clock frequency in Hz.
- BaudRate, 9600, line bit rate in bits/s.
- NrOfDataBits, 8, data bits per frame (legal range 5..9).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset. At the top level it connects directly to KEY[0], not inverted.
- rx  input  1  serial line, idle high; asynchronous to clock.
- readAck  input  1  consumer acknowledge, single-cycle or level.
- dataBits  output  NrOfDataBits  last correctly received word.
- dataValid  output  1  high while dataBits holds an unacknowledged word.
- framingError  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  sticky; set when a word completes while dataValid is already high.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (while reset is low): dataBits = 0, dataValid = 0, framingError = 0, overrun = 0, busy = 0, state = IDLE. The synchronizer flops reset to 1 so the line reads as idle.
- Input path: rx passes through a 2-flop synchronizer. A falling edge is detected between the synchronizer output and its one-cycle-delayed copy.
- Oversample tick:
  - Divisor = round(ClockFrequency / (BaudRate*16)); for the defaults this is 156.
  - The counter free-runs while not in IDLE. It is cleared to 0 on start-edge detection so the bit phase aligns to the edge.
  - Divisor width is $clog2(divisor+1).
- Sample counter: 0..15 ticks per bit. The bit value is the majority of the synchronized samples taken at ticks 7, 8 and 9. The decision is made at tick 9.
- States and transitions:
  - IDLE: a falling edge moves to START.
  - START: at tick 9, a majority of 1 means a glitch, so return to IDLE with no outputs changed. A majority of 0 means a valid start bit; at tick 15 move to DATA.
  - DATA: shift the majority value into the MSB of the shift register (LSB-first reception). After NrOfDataBits bits, at tick 15, move to STOP.
  - STOP, stop majority 1:
    - Load dataBits from the shift register and set dataValid in the cycle after the decision.
    - If dataValid was already 1 and readAck is not asserted in that same cycle, set overrun; the new word still overwrites dataBits.
    - Then return to IDLE immediately, at tick 9, so back-to-back frames are accepted.
  - STOP, stop majority 0: pulse framingError for one cycle; dataBits, dataValid and overrun are unchanged. Move to BREAK.
  - BREAK: wait until the synchronized rx has been high for one full bit time (16 ticks), then go to IDLE. This prevents a break condition from being misread as a start bit.
- Handshake:
  - readAck clears dataValid and overrun in the next cycle.
  - If readAck coincides with a new word load, the load wins: dataValid stays 1 and overrun is not set.
  - readAck while dataValid is 0 has no effect.
- Latency: the start edge on rx reaches the state machine 2 cycles later (synchronizer). dataValid rises (NrOfDataBits+1)*16 + 9 ticks + 1 clock after the edge is detected.
- Reset mid-frame: the frame is abandoned and all outputs take their reset values. After reset is released, a start bit is recognized only on a fresh falling edge; a line that is already low is ignored.
- Baud tolerance: a correctly centred frame must decode with a receiver/transmitter rate mismatch of up to ±3%.

Test Plan:
- Default parameters, one bit = 2496 clocks. Send 0xA5 with a valid stop bit -> dataBits = 0xA5; dataValid rises once, about 23,800 clocks after the start edge; framingError = 0 and overrun = 0 throughout.
- Low glitch of 1000 clocks on an idle line -> state returns to IDLE; dataValid, dataBits and framingError are unchanged; a following 0x3C frame decodes as 0x3C.
- Frame 0x3C with stop bit forced low, line held low for 3 bit times, then high -> one framingError pulse; dataValid stays 0; after recovery, frame 0x11 decodes as 0x11.
- Frames 0x01 then 0x02 back-to-back with no readAck -> dataBits = 0x02, dataValid = 1, overrun = 1. Pulse readAck -> both clear the next cycle. Repeat with readAck coincident with the second load -> overrun stays 0.
- Reset pulled low halfway through a 0xFF frame -> all outputs go to 0 immediately. Release reset while rx is still low -> no frame is decoded until the next falling edge; a following 0x5A decodes correctly.
- Transmitter running 3% fast and then 3% slow, sending 0x00, 0xFF and 0x55 -> all three words decode exactly with no framing errors.
